// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART blocks
package uart_pkg;

   localparam int FRAME_DATA_BITS = 8;

   // Explicit codes keep the encoding stable whether or not the parity state exists.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } tx_state_t;

   function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with clear and one-cycle tick
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   // Count 0..CLKS_PER_BIT-1 while enabled, wrapping on each bit boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tick ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined)
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
   localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_cfg
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
   end

   tx_state_t                    state, state_next;
   logic [FRAME_DATA_BITS-1:0]   shift_reg, shift_next;
   logic [2:0]                   bit_idx, idx_next;
   logic                         tx_q, tx_next;
   logic                         handshake;
   logic                         bit_tick;
`ifdef UART_TX_PARITY_EN
   logic                         parity_q, parity_next;
`endif

   assign tx_ready  = (state == ST_IDLE);
   assign tx_busy   = !tx_ready;
   assign handshake = tx_valid && tx_ready;
   assign tx        = tx_q;

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (handshake),
      .enable (state != ST_IDLE),
      .tick   (bit_tick)
   );

   // Next-state logic; tx_next is the line level for the coming cycle so tx can be a flop.
   always_comb begin
      state_next  = state;
      shift_next  = shift_reg;
      idx_next    = bit_idx;
      tx_next     = tx_q;
`ifdef UART_TX_PARITY_EN
      parity_next = parity_q;
`endif
      case (state)
         ST_IDLE: begin
            tx_next = 1'b1;
            if (tx_valid) begin
               shift_next  = tx_data;
               idx_next    = 3'd0;
               state_next  = ST_START;
               tx_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
               parity_next = ^tx_data;
`endif
            end
         end
         ST_START: begin
            if (bit_tick) begin
               state_next = ST_DATA;
               tx_next    = shift_reg[0];
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               shift_next = {1'b0, shift_reg[FRAME_DATA_BITS-1:1]};
               idx_next   = bit_idx + 3'd1;
               if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_next = ST_PARITY;
                  tx_next    = parity_q;
`else
                  state_next = ST_STOP;
                  tx_next    = 1'b1;
`endif
               end else begin
                  tx_next = shift_reg[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_tick) begin
               state_next = ST_STOP;
               tx_next    = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            tx_next = 1'b1;
            if (bit_tick) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   // State, shifter and line flops; reset aborts any frame and drives the line high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         bit_idx   <= 3'd0;
         tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         shift_reg <= shift_next;
         bit_idx   <= idx_next;
         tx_q      <= tx_next;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_next;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx at 10 clocks per bit
module tb_uart_tx;

   localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
   localparam bit PARITY     = 1'b1;
   localparam int FRAME_BITS = 11;
   localparam int N_FRAMES   = 6;
`else
   localparam bit PARITY     = 1'b0;
   localparam int FRAME_BITS = 10;
   localparam int N_FRAMES   = 4;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CPB;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;

   int checks = 0;
   int failures = 0;
   int hs_count = 0;
   int frames_seen = 0;
   logic [7:0] exp_q[$];

   uart_tx #(
      .CLK_HZ (1_000_000),
      .BAUD   (100_000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .tx_busy  (tx_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Counts handshakes from stable inputs just after each falling edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && tx_valid && tx_ready) hs_count++;
      end
   end

   // Monitor: decodes frames mid-bit and compares against the scoreboard queue.
   initial begin
      bit         active;
      int         cnt;
      int         j;
      logic [7:0] bits;
      logic [7:0] e;
      active = 1'b0;
      cnt = 0;
      bits = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 1'b0;
         end else if (!active) begin
            if (tx === 1'b0) begin
               active = 1'b1;
               cnt = 1;
            end
         end else begin
            cnt++;
            if (cnt % CPB == CPB / 2) begin
               j = cnt / CPB;
               if (j == 0) begin
                  chk("mon_start", int'(tx), 0);
               end else if (j <= 8) begin
                  bits[j-1] = tx;
               end else if (PARITY && j == 9) begin
                  chk("mon_parity", int'(tx), int'(^bits));
               end else begin
                  chk("mon_stop", int'(tx), 1);
                  if (exp_q.size() == 0) begin
                     chk("mon_unexpected_frame", 0, 1 + int'(bits));
                  end else begin
                     e = exp_q.pop_front();
                     chk("mon_byte", int'(bits), int'(e));
                  end
                  frames_seen++;
                  active = 1'b0;
               end
            end
         end
      end
   end

   // Present a byte and wait (bounded) for the handshake edge; returns 1 time unit after it.
   task automatic do_handshake(input logic [7:0] b, input bit push, input bit hold);
      int budget;
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      budget   = 0;
      while (!tx_ready && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      if (!tx_ready) begin
         checks++;
         failures++;
         $display("FAIL handshake_timeout actual=busy required=ready");
         tx_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (push) exp_q.push_back(b);
      #1;
      if (!hold) tx_valid = 1'b0;
   endtask

   // Cycle-exact line check for one frame starting right after its handshake edge.
   task automatic verify_frame(input logic [7:0] b);
      int   bi;
      logic e;
      for (int k = 1; k <= FRAME_CYC; k++) begin
         @(negedge clk);
         bi = (k - 1) / CPB;
         if (bi == 0)                 e = 1'b0;
         else if (bi <= 8)            e = b[bi-1];
         else if (PARITY && bi == 9)  e = ^b;
         else                         e = 1'b1;
         chk($sformatf("frame_%02h_tx_k%0d", b, k), int'(tx), int'(e));
         chk($sformatf("frame_%02h_ready_k%0d", b, k), int'(tx_ready), 0);
         chk($sformatf("frame_%02h_busy_k%0d", b, k), int'(tx_busy), 1);
      end
      @(negedge clk);
      chk("ready_after_frame", int'(tx_ready), 1);
      chk("busy_after_frame", int'(tx_busy), 0);
      chk("tx_after_frame", int'(tx), 1);
   endtask

   initial begin
      int hs_base;
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      @(negedge clk);
      chk("reset_tx", int'(tx), 1);
      chk("reset_ready", int'(tx_ready), 1);
      chk("reset_busy", int'(tx_busy), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_tx", int'(tx), 1);
         chk("idle_ready", int'(tx_ready), 1);
         chk("idle_busy", int'(tx_busy), 0);
      end

      do_handshake(8'h55, 1'b1, 1'b0);
      verify_frame(8'h55);

      hs_base = hs_count;
      do_handshake(8'hA5, 1'b1, 1'b1);
      tx_data = 8'h0F;
      verify_frame(8'hA5);
      @(posedge clk);
      exp_q.push_back(8'h0F);
      #1;
      tx_valid = 1'b0;
      verify_frame(8'h0F);
      chk("b2b_handshakes", hs_count - hs_base, 2);

      hs_base = hs_count;
      do_handshake(8'h00, 1'b1, 1'b0);
      fork
         verify_frame(8'h00);
         begin
            repeat (29) @(negedge clk);
            tx_data  = 8'hFF;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
         end
      join
      repeat (20) @(negedge clk) chk("post_ignore_tx", int'(tx), 1);
      chk("ignore_handshakes", hs_count - hs_base, 1);

      do_handshake(8'h00, 1'b0, 1'b0);
      repeat (45) @(negedge clk);
      chk("pre_reset_tx", int'(tx), 0);
      rst_n = 1'b0;
      #1;
      chk("abort_tx", int'(tx), 1);
      chk("abort_ready", int'(tx_ready), 1);
      chk("abort_busy", int'(tx_busy), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         chk("post_abort_tx", int'(tx), 1);
         chk("post_abort_ready", int'(tx_ready), 1);
      end

`ifdef UART_TX_PARITY_EN
      do_handshake(8'h07, 1'b1, 1'b0);
      verify_frame(8'h07);
      do_handshake(8'h03, 1'b1, 1'b0);
      verify_frame(8'h03);
`endif

      repeat (20) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("frames_seen", frames_seen, N_FRAMES);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
